inv_sub_bytes_add_key_iter: RTL
===============================

// Module: inv_sub_bytes_add_key_iter
// PURPOSE
//  Iterative AES decryption datapath stage: InvSubBytes then AddRoundKey on one 128-bit state.
//  Sits directly upstream of the InvMixColumns stage.
//  Input is the state after InvShiftRows; out_state feeds the InvMixColumns prevState input unchanged.
//  Processes LANES bytes per cycle through LANES inverse S-box instances (area/latency trade).
//  valid/ready handshake on both sides; one block in flight.
// PARAMETERS
//  LANES  4  bytes processed per cycle; legal 1,2,4,8,16; N = 16/LANES processing cycles
// PORTS
//  clk        in   1    single clock, all flops rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    in_state/in_key valid
//  in_ready   out  1    block accepts input (high only in IDLE)
//  in_state   in   128  state after InvShiftRows; byte k = bits[127-8k -: 8], column-major (byte 0 = s[0][0])
//  in_key     in   128  round key, same byte order
//  out_valid  out  1    out_state holds a finished result
//  out_ready  in   1    downstream accepts result
//  out_state  out  128  InvSbox(in_state[k]) ^ in_key[k] for every byte k
//  busy       out  1    high in PROC or DONE
// BEHAVIOUR
//  Interface: one clock, asynchronous active-low reset rst_n.
//  Reset (async assert, sync deassert): state=IDLE, cnt=0, out_valid=0, out_state=0, busy=0.
//  in_ready = (state==IDLE); inputs are ignored while rst_n low.
//  FSM IDLE -> PROC -> DONE -> IDLE:
//   IDLE: on in_valid&&in_ready, capture in_state and in_key into internal regs; cnt=0; -> PROC.
//   PROC: each cycle, bytes k = cnt*LANES .. cnt*LANES+LANES-1 are replaced by InvSbox(byte)^key byte;
//    cnt++. After processing lanes group N-1, -> DONE and out_valid=1 at that same edge.
//   DONE: out_valid=1; out_state and out_valid stay stable while out_ready=0 (no timeout).
//    On out_valid&&out_ready: out_valid=0; -> IDLE.
//  No input accept in the same cycle as the output handshake.
//  Latency: out_valid rises N edges after the accept edge (LANES=4 -> 4).
//  Throughput: one block per N+2 cycles with out_ready held high.
//  cnt width is clog2(N), minimum 1. With LANES=16: PROC lasts exactly one cycle.
//  out_state is driven from the working register and is undefined while out_valid=0.
//  Downstream must sample it only on handshake.
//  Inverse S-box: full FIPS-197 256-entry table, combinational, one instance per lane.
//  Pure XOR in GF(2^8); no carries; widths are 8-bit per byte.
//  in_valid held high in PROC/DONE has no effect; the captured block is not disturbed.
//  Reset mid-PROC or mid-DONE aborts the block: no out_valid pulse and the result is lost.
//   After rst_n deasserts, in_ready is high.
// TESTING
//  T1 reset: rst_n=0 -> out_valid=0, out_state=0, busy=0, in_ready=1; release -> IDLE.
//  T2 in_state=all 0x00, in_key=0 -> after 4 cycles out_valid=1, out_state=all 0x52.
//  T3 in_state=all 0x63, in_key=0x000102..0f.
//   -> out_state=0x000102030405060708090a0b0c0d0e0f.
//  T4 backpressure: out_ready=0 for 10 cycles in DONE.
//   -> out_valid, out_state stable; in_ready=0; busy=1.
//   Then out_ready=1 -> IDLE the next cycle.
//  T5 reset asserted at PROC cnt=2 -> out_valid never rises; next block (all 0xff, key 0).
//   -> all 0x7d.
//  T6 exhaustive: 16 blocks cover bytes 0x00..0xff with random keys; back-to-back, out_ready=1.
//   -> match reference model at one block per N+2 cycles; rerun for LANES=1,16.

Source files
------------

// File: rtl/inv_sub_bytes_add_key_iter.sv
`default_nettype none
// ============================================================================
//  Module      : inv_sub_bytes_add_key_iter
//  Description : Iterative AES InvSubBytes + AddRoundKey over one 128-bit
//                state, LANES bytes per cycle, valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module inv_sub_bytes_add_key_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int c_NUM_STEPS = 16 / LANES;
    localparam int c_CNT_W     = (c_NUM_STEPS > 1) ? $clog2(c_NUM_STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(c_NUM_STEPS - 1);

    localparam logic [7:0] c_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } stateT;

    stateT              r_state;
    stateT              w_nextState;
    logic               w_accept;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_outValid;
    logic [127:0]       r_work;
    logic [127:0]       r_key;
    logic [127:0]       w_nextWork;
    logic [7:0]         w_workBytes [16];
    logic [7:0]         w_keyBytes  [16];
    logic [7:0]         w_laneOut   [LANES];

    for (genvar k = 0; k < 16; k++) begin : g_bytes
        assign w_workBytes[k] = r_work[127-8*k -: 8];
        assign w_keyBytes[k]  = r_key[127-8*k -: 8];
    end

    // Lane l of step cnt handles byte cnt*LANES+l
    for (genvar l = 0; l < LANES; l++) begin : g_lanes
        logic [3:0] w_idx;
        assign w_idx        = 4'(r_cnt) * 4'(LANES) + 4'(l);
        assign w_laneOut[l] = c_INV_SBOX[w_workBytes[w_idx]] ^ w_keyBytes[w_idx];
    end

    for (genvar k = 0; k < 16; k++) begin : g_merge
        assign w_nextWork[127-8*k -: 8] = (r_cnt == c_CNT_W'(k / LANES)) ? w_laneOut[k % LANES]
                                                                         : w_workBytes[k];
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = S_PROC;
                end
            end
            S_PROC: begin
                if (r_cnt == c_LAST_STEP) w_nextState = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_outValid <= 1'b0;
            r_work     <= '0;
            r_key      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work <= in_state;
                        r_key  <= in_key;
                        r_cnt  <= '0;
                    end
                end
                S_PROC: begin
                    r_work <= w_nextWork;
                    if (r_cnt == c_LAST_STEP) begin
                        r_cnt      <= '0;
                        r_outValid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_outValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_outValid;
    assign out_state = r_work;

endmodule
`default_nettype wire
